// File: rtl/xyolo_write_pingpong.sv
// xyolo_write_pingpong
// Double-buffered output stage for the xyolo vector. N_CH channel results are
// written into a fill bank by the address generator. Meanwhile the other bank
// drains to one databus write port as full-width words. Each bank drain is
// placed at its own strided external address. A swap that arrives while the
// drain side is still busy raises a sticky overflow flag. Signed 8-bit
// saturation can optionally be applied on the drain path.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   run                 start pulse, honoured only while done=1
//   cfg_*               run configuration, latched on an accepted run
//   wr_en/addr/data     per-channel fill-bank write port (never stalls)
//   swap / swap_ready   hand the filled bank over to the drain side
//   databus_*           valid/ready write port to the external bus
//   done                all configured bank drains are complete
//   overflow            sticky: a swap was refused because the drain was busy
//
// Drain FSM states:
//   state   | meaning
//   D_IDLE  | no bank draining; swap_ready=1
//   D_READ  | read word j of the drain bank
//   D_WRITE | databus_valid=1, held until databus_ready
//   D_DONE  | bank finished; advance k, reopen swap, maybe finish the run
module xyolo_write_pingpong #(
    parameter int DATAPATH_W = 16,
    parameter int N_CH       = 16,
    parameter int ADDR_W     = 6,
    parameter int IO_ADDR_W  = 32,
    parameter int DATABUS_W  = N_CH * DATAPATH_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [IO_ADDR_W-1:0]     cfg_ext_addr,
    input  logic [ADDR_W:0]          cfg_len,
    input  logic [IO_ADDR_W-1:0]     cfg_stride,
    input  logic [15:0]              cfg_iter,
    input  logic                     cfg_sat8,
    input  logic [N_CH-1:0]          wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATABUS_W-1:0]     wr_data,
    input  logic                     swap,
    output logic                     swap_ready,
    input  logic                     databus_ready,
    output logic                     databus_valid,
    output logic [IO_ADDR_W-1:0]     databus_addr,
    output logic [DATABUS_W-1:0]     databus_wdata,
    output logic [DATABUS_W/8-1:0]   databus_wstrb,
    output logic                     done,
    output logic                     overflow
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int BUS_BYTES = DATABUS_W / 8;
    localparam logic signed [DATAPATH_W-1:0] SAT_HI = DATAPATH_W'(127);
    localparam logic signed [DATAPATH_W-1:0] SAT_LO = DATAPATH_W'(-128);

    typedef enum logic [1:0] {
        D_IDLE,
        D_READ,
        D_WRITE,
        D_DONE
    } drain_state_t;

    // Two banks; each word holds all channels side by side.
    logic [DATABUS_W-1:0] bank_mem [2][DEPTH];

    drain_state_t         state_q, state_d;
    logic                 fill_bank_q, fill_bank_d;
    logic                 swap_ready_q, swap_ready_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic [ADDR_W:0]      j_q, j_d;
    logic [15:0]          k_q, k_d;
    logic [IO_ADDR_W-1:0] bank_base_q, bank_base_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic [IO_ADDR_W-1:0] stride_q, stride_d;
    logic [15:0]          iter_q, iter_d;
    logic                 sat8_q, sat8_d;
    logic                 valid_q, valid_d;
    logic [IO_ADDR_W-1:0] addr_q, addr_d;
    logic [DATABUS_W-1:0] wdata_q, wdata_d;

    logic                 start;
    logic                 swap_ok;
    logic [DATABUS_W-1:0] rd_word;

    function automatic logic [DATABUS_W-1:0] saturate(input logic [DATABUS_W-1:0] word);
        logic [DATABUS_W-1:0]         res;
        logic signed [DATAPATH_W-1:0] v;
        res = word;
        for (int c = 0; c < N_CH; c++) begin
            v = word[c*DATAPATH_W +: DATAPATH_W];
            if (v > SAT_HI) begin
                res[c*DATAPATH_W +: DATAPATH_W] = SAT_HI;
            end else if (v < SAT_LO) begin
                res[c*DATAPATH_W +: DATAPATH_W] = SAT_LO;
            end
        end
        return res;
    endfunction

    // Fill port: the bank index is sampled before a same-cycle swap toggles it,
    // so a write on the swap cycle still lands in the bank being handed over.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (wr_en[c] && !done_q) begin
                bank_mem[fill_bank_q][wr_addr][c*DATAPATH_W +: DATAPATH_W] <=
                    wr_data[c*DATAPATH_W +: DATAPATH_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_bank_d  = fill_bank_q;
        swap_ready_d = swap_ready_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        j_d          = j_q;
        k_d          = k_q;
        bank_base_d  = bank_base_q;
        len_d        = len_q;
        stride_d     = stride_q;
        iter_d       = iter_q;
        sat8_d       = sat8_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        start   = run && done_q;
        swap_ok = swap && swap_ready_q && !done_q;
        // The drain bank is always the one not being filled.
        rd_word = bank_mem[~fill_bank_q][j_q[ADDR_W-1:0]];

        if (start) begin
            done_d      = 1'b0;
            overflow_d  = 1'b0;
            fill_bank_d = 1'b0;
            k_d         = '0;
            j_d         = '0;
            bank_base_d = cfg_ext_addr;
            len_d       = cfg_len;
            stride_d    = cfg_stride;
            iter_d      = cfg_iter;
            sat8_d      = cfg_sat8;
        end

        if (swap && !swap_ready_q && !done_q) begin
            overflow_d = 1'b1;
        end

        if (swap_ok) begin
            fill_bank_d  = ~fill_bank_q;
            swap_ready_d = 1'b0;
        end

        case (state_q)
            D_IDLE: begin
                if (swap_ok) begin
                    state_d = D_READ;
                end
            end
            D_READ: begin
                valid_d = 1'b1;
                addr_d  = bank_base_q + (IO_ADDR_W'(j_q) * IO_ADDR_W'(BUS_BYTES));
                wdata_d = sat8_q ? saturate(rd_word) : rd_word;
                state_d = D_WRITE;
            end
            D_WRITE: begin
                if (databus_ready) begin
                    valid_d = 1'b0;
                    j_d     = j_q + 1'b1;
                    state_d = ((j_q + 1'b1) == len_q) ? D_DONE : D_READ;
                end
            end
            D_DONE: begin
                k_d          = k_q + 16'd1;
                j_d          = '0;
                bank_base_d  = bank_base_q + stride_q;
                swap_ready_d = 1'b1;
                if ((k_q + 16'd1) == iter_q) begin
                    done_d = 1'b1;
                end
                state_d = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= D_IDLE;
            fill_bank_q  <= 1'b0;
            swap_ready_q <= 1'b1;
            done_q       <= 1'b1;
            overflow_q   <= 1'b0;
            j_q          <= '0;
            k_q          <= '0;
            bank_base_q  <= '0;
            len_q        <= '0;
            stride_q     <= '0;
            iter_q       <= '0;
            sat8_q       <= 1'b0;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            fill_bank_q  <= fill_bank_d;
            swap_ready_q <= swap_ready_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            j_q          <= j_d;
            k_q          <= k_d;
            bank_base_q  <= bank_base_d;
            len_q        <= len_d;
            stride_q     <= stride_d;
            iter_q       <= iter_d;
            sat8_q       <= sat8_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign swap_ready    = swap_ready_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign databus_valid = valid_q;
    assign databus_addr  = addr_q;
    assign databus_wdata = wdata_q;
    assign databus_wstrb = {BUS_BYTES{valid_q}};

endmodule

// File: tb/tb_xyolo_write_pingpong.sv
// Directed bench for xyolo_write_pingpong: the bench keeps its own copy of both
// banks, predicts every bus transfer (address and data) when a swap is issued,
// and checks each handshake against that prediction.
module tb_xyolo_write_pingpong;

    localparam int DW  = 16;
    localparam int NC  = 16;
    localparam int AW  = 6;
    localparam int IOW = 32;
    localparam int BW  = NC * DW;
    localparam int NB  = BW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           run = 1'b0;
    logic [IOW-1:0] cfg_ext_addr = '0;
    logic [AW:0]    cfg_len = '0;
    logic [IOW-1:0] cfg_stride = '0;
    logic [15:0]    cfg_iter = '0;
    logic           cfg_sat8 = 1'b0;
    logic [NC-1:0]  wr_en = '0;
    logic [AW-1:0]  wr_addr = '0;
    logic [BW-1:0]  wr_data = '0;
    logic           swap = 1'b0;
    logic           swap_ready;
    logic           databus_ready = 1'b1;
    logic           databus_valid;
    logic [IOW-1:0] databus_addr;
    logic [BW-1:0]  databus_wdata;
    logic [NB-1:0]  databus_wstrb;
    logic           done;
    logic           overflow;

    xyolo_write_pingpong dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .cfg_ext_addr  (cfg_ext_addr),
        .cfg_len       (cfg_len),
        .cfg_stride    (cfg_stride),
        .cfg_iter      (cfg_iter),
        .cfg_sat8      (cfg_sat8),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .swap          (swap),
        .swap_ready    (swap_ready),
        .databus_ready (databus_ready),
        .databus_valid (databus_valid),
        .databus_addr  (databus_addr),
        .databus_wdata (databus_wdata),
        .databus_wstrb (databus_wstrb),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IOW-1:0] addr;
        logic [BW-1:0]  data;
    } xfer_t;

    xfer_t          exp_q[$];
    xfer_t          e_pop;
    logic [IOW-1:0] obs_addr[$];
    logic [BW-1:0]  obs_data[$];
    logic [BW-1:0]  ref_mem [2][64];

    int checks = 0;
    int errors = 0;

    // Spec-level model state
    int             m_fill;
    int             m_k;
    int             m_len;
    logic [IOW-1:0] m_base;
    logic [IOW-1:0] m_stride;
    bit             m_sat;
    bit             m_active = 1'b0;

    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [IOW-1:0] prev_addr;
    logic [BW-1:0]  prev_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pat(input int j, input int off);
        logic [BW-1:0] w;
        for (int c = 0; c < NC; c++) w[c*DW +: DW] = 16'(off + 16 * j + c);
        return w;
    endfunction

    function automatic logic [BW-1:0] sat_model(input logic [BW-1:0] w, input bit en);
        logic [BW-1:0] r;
        int v;
        r = w;
        for (int c = 0; c < NC; c++) begin
            v = $signed(w[c*DW +: DW]);
            if (en && v > 127) v = 127;
            if (en && v < -128) v = -128;
            r[c*DW +: DW] = 16'(v);
        end
        return r;
    endfunction

    // Compare process: every handshake must match the next predicted transfer,
    // and a stalled request must hold still until it is accepted.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            chk("wstrb", 32'(databus_wstrb), {NB{databus_valid}});
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(databus_valid), 32'd1);
                chk("hold_addr", databus_addr, prev_addr);
                chkw("hold_wdata", databus_wdata, prev_wdata);
            end
            if (databus_valid && databus_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got addr %h, expected no transfer", databus_addr);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("xfer_addr", databus_addr, e_pop.addr);
                    chkw("xfer_data", databus_wdata, e_pop.data);
                end
                obs_addr.push_back(databus_addr);
                obs_data.push_back(databus_wdata);
            end
            prev_valid = databus_valid;
            prev_ready = databus_ready;
            prev_addr  = databus_addr;
            prev_wdata = databus_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input logic [31:0] base, input int len, input logic [31:0] stride,
                          input int iter, input bit sat);
        cfg_ext_addr = base;
        cfg_len      = 7'(len);
        cfg_stride   = stride;
        cfg_iter     = 16'(iter);
        cfg_sat8     = sat;
        run = 1'b1;
        tick();
        run = 1'b0;
        m_base = base; m_len = len; m_stride = stride; m_sat = sat;
        m_fill = 0; m_k = 0; m_active = 1'b1;
        obs_addr.delete();
        obs_data.delete();
        chk("run_done_low", 32'(done), 32'd0);
        chk("run_ovf_clear", 32'(overflow), 32'd0);
        // Scramble the config inputs; the run must use the latched copy.
        cfg_ext_addr = 32'hDEAD_0000;
        cfg_len      = 7'd3;
        cfg_stride   = 32'h5;
        cfg_iter     = 16'd9;
        cfg_sat8     = ~sat;
    endtask

    task automatic write_word(input int a, input logic [15:0] en, input logic [BW-1:0] w);
        wr_en = en; wr_addr = 6'(a); wr_data = w;
        tick();
        wr_en = '0;
        if (m_active)
            for (int c = 0; c < NC; c++)
                if (en[c]) ref_mem[m_fill][a][c*DW +: DW] = w[c*DW +: DW];
    endtask

    // Swap with an optional write on the same cycle (it belongs to the old bank).
    task automatic do_swap(input bit accept, input int a, input logic [15:0] en, input logic [BW-1:0] w);
        xfer_t e;
        chk("swap_ready_pre", 32'(swap_ready), 32'(accept));
        swap = 1'b1; wr_en = en; wr_addr = 6'(a); wr_data = w;
        tick();
        swap = 1'b0; wr_en = '0;
        if (m_active)
            for (int c = 0; c < NC; c++)
                if (en[c]) ref_mem[m_fill][a][c*DW +: DW] = w[c*DW +: DW];
        if (accept) begin
            for (int j = 0; j < m_len; j++) begin
                e.addr = m_base + 32'(m_k) * m_stride + 32'(j * NB);
                e.data = sat_model(ref_mem[m_fill][j], m_sat);
                exp_q.push_back(e);
            end
            m_fill ^= 1;
            m_k++;
        end
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
        chk({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_swap_ready(input string tag);
        int n = 0;
        while (!swap_ready && n < 200) begin tick(); n++; end
        chk({tag, "_swap_ready_timeout"}, 32'(swap_ready), 32'd1);
    endtask

    // Last bank: done must rise exactly two cycles after the final handshake.
    task automatic finish_run(input string tag);
        wait_drained(tag);
        chk({tag, "_done_h1"}, 32'(done), 32'd0);
        tick();
        chk({tag, "_done_h2"}, 32'(done), 32'd1);
        chk({tag, "_swap_ready_end"}, 32'(swap_ready), 32'd1);
        m_active = 1'b0;
    endtask

    task automatic scen_single(input string tag);
        logic [31:0] s1_addr[4] = '{32'h1000, 32'h1020, 32'h1040, 32'h1060};
        do_run(32'h1000, 4, 32'h0, 1, 1'b0);
        for (int j = 0; j < 3; j++) write_word(j, 16'hFFFF, pat(j, 0));
        do_swap(1'b1, 3, 16'hFFFF, pat(3, 0));
        chk({tag, "_valid_t1"}, 32'(databus_valid), 32'd0);
        tick();
        chk({tag, "_valid_t2"}, 32'(databus_valid), 32'd1);
        chk({tag, "_first_addr"}, databus_addr, 32'h1000);
        finish_run(tag);
        chk({tag, "_n_xfer"}, 32'(obs_addr.size()), 32'd4);
        for (int j = 0; j < 4 && j < obs_addr.size(); j++) begin
            chk({tag, "_addr_lit"}, obs_addr[j], s1_addr[j]);
            chk({tag, "_ch0_lit"}, 32'(obs_data[j][15:0]), 32'(16 * j));
            chk({tag, "_ch15_lit"}, 32'(obs_data[j][15*DW +: DW]), 32'(16 * j + 15));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] s2_addr[4] = '{32'h1000, 32'h1020, 32'h1400, 32'h1420};
        logic [BW-1:0] sw;
        int n;

        // Reset
        #2 rst = 1'b0;
        tick(); tick();
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_swap_ready", 32'(swap_ready), 32'd1);
        chk("rst_valid", 32'(databus_valid), 32'd0);
        chk("rst_addr", databus_addr, 32'd0);
        chkw("rst_wdata", databus_wdata, '0);
        chk("rst_wstrb", 32'(databus_wstrb), 32'd0);
        rst = 1'b1;
        tick();

        // 1: single bank
        scen_single("s1");

        // 2: ping-pong with concurrent fill, partial channel enables
        do_run(32'h1000, 2, 32'h400, 2, 1'b0);
        write_word(0, 16'hFFFF, pat(0, 'h100));
        write_word(1, 16'hFFFF, pat(1, 'h100));
        do_swap(1'b1, 0, 16'h0, '0);
        write_word(0, 16'hFFFF, pat(0, 'h800));
        write_word(1, 16'hFFFF, pat(1, 'h800));
        write_word(1, 16'h00F0, pat(1, 'hA00));
        wait_swap_ready("s2");
        do_swap(1'b1, 0, 16'h0, '0);
        finish_run("s2");
        chk("s2_n_xfer", 32'(obs_addr.size()), 32'd4);
        for (int j = 0; j < 4 && j < obs_addr.size(); j++) chk("s2_addr_lit", obs_addr[j], s2_addr[j]);
        if (obs_data.size() == 4) begin
            chk("s2_b0_ch0_lit", 32'(obs_data[0][15:0]), 32'h0100);
            chk("s2_b1_ch0_lit", 32'(obs_data[3][15:0]), 32'h0810);
            chk("s2_b1_ch4_lit", 32'(obs_data[3][4*DW +: DW]), 32'h0A14);
        end
        // swap with done=1: no drain, no flag
        swap = 1'b1; tick(); swap = 1'b0;
        repeat (4) tick();
        chk("s2_late_swap_ovf", 32'(overflow), 32'd0);
        chk("s2_late_swap_done", 32'(done), 32'd1);
        chk("s2_late_swap_n", 32'(obs_addr.size()), 32'd4);

        // 3: backpressure on word 1, plus a run pulse that must be ignored
        do_run(32'h2000, 3, 32'h0, 1, 1'b0);
        for (int j = 0; j < 3; j++) write_word(j, 16'hFFFF, pat(j, 'h300));
        do_swap(1'b1, 0, 16'h0, '0);
        n = 0;
        while (obs_addr.size() < 1 && n < 50) begin tick(); n++; end
        databus_ready = 1'b0;
        n = 0;
        while (!databus_valid && n < 50) begin tick(); n++; end
        chk("s3_stall_valid", 32'(databus_valid), 32'd1);
        run = 1'b1; tick(); run = 1'b0;
        repeat (4) tick();
        chk("s3_no_xfer_stalled", 32'(obs_addr.size()), 32'd1);
        chk("s3_stall_addr", databus_addr, 32'h2020);
        databus_ready = 1'b1;
        tick();
        chk("s3_one_on_release", 32'(obs_addr.size()), 32'd2);
        finish_run("s3");
        chk("s3_n_xfer", 32'(obs_addr.size()), 32'd3);

        // 4: overflow
        do_run(32'h3000, 4, 32'h100, 2, 1'b0);
        for (int j = 0; j < 4; j++) write_word(j, 16'hFFFF, pat(j, 'h400));
        do_swap(1'b1, 0, 16'h0, '0);
        do_swap(1'b0, 0, 16'h0, '0);
        chk("s4_ovf_set", 32'(overflow), 32'd1);
        for (int j = 0; j < 4; j++) write_word(j, 16'hFFFF, pat(j, 'h500));
        wait_swap_ready("s4");
        chk("s4_one_bank", 32'(obs_addr.size()), 32'd4);
        chk("s4_ovf_sticky", 32'(overflow), 32'd1);
        do_swap(1'b1, 0, 16'h0, '0);
        finish_run("s4");
        chk("s4_n_xfer", 32'(obs_addr.size()), 32'd8);
        if (obs_addr.size() == 8) chk("s4_bank1_addr_lit", obs_addr[4], 32'h3100);
        chk("s4_ovf_after", 32'(overflow), 32'd1);

        // 5: saturation, then the stored word re-drained raw
        do_run(32'h4000, 1, 32'h0, 1, 1'b1);
        sw = '0;
        sw[0*DW +: DW] = 16'h0200; sw[1*DW +: DW] = 16'hFF00;
        sw[2*DW +: DW] = 16'h0050; sw[3*DW +: DW] = 16'hFF90;
        sw[4*DW +: DW] = 16'h7FFF; sw[5*DW +: DW] = 16'h8000;
        sw[6*DW +: DW] = 16'h007F; sw[7*DW +: DW] = 16'hFF80;
        sw[8*DW +: DW] = 16'h0080; sw[9*DW +: DW] = 16'hFF7F;
        write_word(0, 16'hFFFF, sw);
        do_swap(1'b1, 0, 16'h0, '0);
        finish_run("s5");
        if (obs_data.size() == 1) begin
            chk("s5_ch0_lit", 32'(obs_data[0][0*DW +: DW]), 32'h007F);
            chk("s5_ch1_lit", 32'(obs_data[0][1*DW +: DW]), 32'hFF80);
            chk("s5_ch2_lit", 32'(obs_data[0][2*DW +: DW]), 32'h0050);
            chk("s5_ch3_lit", 32'(obs_data[0][3*DW +: DW]), 32'hFF90);
            chk("s5_ch8_lit", 32'(obs_data[0][8*DW +: DW]), 32'h007F);
            chk("s5_ch9_lit", 32'(obs_data[0][9*DW +: DW]), 32'hFF80);
        end else chk("s5_n_xfer", 32'(obs_data.size()), 32'd1);
        write_word(0, 16'hFFFF, pat(0, 'h600));
        do_run(32'h4000, 1, 32'h0, 1, 1'b0);
        do_swap(1'b1, 0, 16'h0, '0);
        finish_run("s5b");
        if (obs_data.size() == 1) begin
            chk("s5b_raw_ch0_lit", 32'(obs_data[0][0*DW +: DW]), 32'h0200);
            chk("s5b_raw_ch1_lit", 32'(obs_data[0][1*DW +: DW]), 32'hFF00);
        end else chk("s5b_n_xfer", 32'(obs_data.size()), 32'd1);

        // 6: asynchronous reset while a request is stalled
        do_run(32'h5000, 4, 32'h0, 1, 1'b0);
        for (int j = 0; j < 4; j++) write_word(j, 16'hFFFF, pat(j, 'h700));
        databus_ready = 1'b0;
        do_swap(1'b1, 0, 16'h0, '0);
        n = 0;
        while (!databus_valid && n < 20) begin tick(); n++; end
        chk("s6_pre_valid", 32'(databus_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("s6_valid_async", 32'(databus_valid), 32'd0);
        chk("s6_done_async", 32'(done), 32'd1);
        chk("s6_swap_ready_async", 32'(swap_ready), 32'd1);
        chk("s6_wstrb_async", 32'(databus_wstrb), 32'd0);
        chk("s6_addr_async", databus_addr, 32'd0);
        exp_q.delete();
        m_active = 1'b0;
        tick(); tick();
        rst = 1'b1;
        databus_ready = 1'b1;
        tick();
        scen_single("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xyolo_write_pingpong.md
Name: xyolo_write_pingpong

Overview:
- Parametrised output stage for the xyolo vector: N_CH xyolo results per pixel are buffered in a double-buffered (ping/pong) per-channel memory.
- One bank is filled by the internal address generator while the other drains to the external databus as full-width words.
- Adds what the single-bank write stage lacks: concurrent fill/drain, per-bank strided external addressing, overflow detection and optional signed 8-bit saturation.
- Sits between the xyolo array outputs and one databus write port.

Parameters:
DATAPATH_W, 16, channel data width (bits)
N_CH, 16, number of channels / xyolo units
ADDR_W, 6, per-bank word address width (bank depth 2^ADDR_W)
IO_ADDR_W, 32, external byte address width
DATABUS_W, N_CH*DATAPATH_W, databus width (derived; not overridden independently)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
run  in  1  start pulse; sampled only when done=1
cfg_ext_addr  in  IO_ADDR_W  external byte base address
cfg_len  in  ADDR_W+1  words drained per bank, 1..2^ADDR_W
cfg_stride  in  IO_ADDR_W  byte offset between consecutive bank drains
cfg_iter  in  16  total bank drains per run, >=1
cfg_sat8  in  1  1: saturate each channel to [-128,127], sign-extended
wr_en  in  N_CH  per-channel write enable into fill bank
wr_addr  in  ADDR_W  fill word address
wr_data  in  DATABUS_W  channel c at bits [c*DATAPATH_W +: DATAPATH_W]
swap  in  1  fill bank complete; hand to drain
swap_ready  out  1  drain side idle; swap will be accepted
databus_ready  in  1  write accepted
databus_valid  out  1  write request
databus_addr  out  IO_ADDR_W  byte address
databus_wdata  out  DATABUS_W  packed channels, channel c at [c*DATAPATH_W +: DATAPATH_W]
databus_wstrb  out  DATABUS_W/8  all ones while valid, else 0
done  out  1  all cfg_iter drains complete
overflow  out  1  sticky: swap arrived with swap_ready=0

Behaviour:
- Reset (rst=0, async): done=1, overflow=0, swap_ready=1, databus_valid=0, databus_addr=0, databus_wdata=0, databus_wstrb=0, fill bank=0, drain counters=0. Memory contents undefined.
- Mid-operation reset aborts everything immediately, including an in-flight valid.
- run with done=1: cfg_* latched, done=0 next cycle, overflow cleared, fill bank=0, drain count k=0.
- run with done=0 is ignored.
- Fill: while done=0, wr_en[c] writes wr_data channel c at wr_addr of the fill bank. Writes are always accepted; no backpressure.
- Swap accepted when swap=1 and swap_ready=1 and done=0:
  - fill bank toggles; the previous fill bank becomes the drain bank; swap_ready=0 next cycle.
  - A write on the swap cycle lands in the old bank.
- Swap with swap_ready=0: ignored, overflow=1 (sticky until next run). Swap with done=1: ignored, no flag.
- Drain FSM D_IDLE -> D_READ -> D_WRITE -> (D_READ | D_DONE):
  - D_READ: read word j of drain bank (1-cycle memory latency).
  - D_WRITE: databus_valid=1.
    - databus_addr = cfg_ext_addr + k*cfg_stride + j*(DATABUS_W/8), modulo 2^IO_ADDR_W.
    - databus_wdata = word j after optional saturation.
  - valid, addr, wdata and wstrb stay stable until databus_ready=1. valid never drops without ready.
  - Handshake cycle: j++. If j==cfg_len, go to D_DONE; else go to D_READ (valid=0 for one cycle).
  - D_DONE: k++, j=0. swap_ready=1 next cycle. If k==cfg_iter, done=1. Return to D_IDLE.
- Timing: swap accepted at t -> first valid at t+2. Steady throughput is one word per 2 cycles with ready=1.
- Saturation: when cfg_sat8=1, the signed value v becomes min(max(v,-128),127), sign-extended to DATAPATH_W. Applied on drain only; stored data is untouched.
- Final bank: the last swap must arrive after the final fill. Swaps after k reaches cfg_iter are ignored (done=1).

Test Plan:
1. Single bank: cfg_len=4, cfg_iter=1, base 0x1000, fill words 0..3 with channel c = 16*j+c, swap → four writes at 0x1000, 0x1020, 0x1040, 0x1060 with the matching data; done=1 two cycles after the last handshake.
2. Ping-pong: cfg_iter=2, stride 0x400, cfg_len=2. Fill bank 1 during drain of bank 0, then swap → addresses 0x1000, 0x1020, 0x1400, 0x1420; bank-1 data is not corrupted by concurrent fill.
3. Backpressure: hold databus_ready=0 for 5 cycles on word 1 → valid, addr and wdata are bit-stable throughout; exactly one transfer on release.
4. Overflow: a second swap while draining → ignored, overflow=1, drain count unchanged; next run clears overflow.
5. Saturation: cfg_sat8=1, channel values 0x0200, 0xFF00, 0x0050, 0xFF90 → drained 0x007F, 0xFF80, 0x0050, 0xFF90.
6. Reset mid-drain with ready=0 → valid=0 and done=1 immediately (asynchronous); a subsequent run behaves as in scenario 1.
